load_store_unit: RTL and testbench

- Core-side initiator for data memory accesses; sits between execute stage and the memory unit.
- Accepts one load/store request per handshake and converts it into word-aligned memory cycles.
- Sub-word stores use read-modify-write; loads are returned byte/halfword-extracted and sign/zero-extended.
- Returns one response per request, with an error flag for misaligned (and optionally illegal-region) accesses.

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into word-aligned memory cycles,
// with read-modify-write for sub-word stores. Optional macro LSU_REGION_CHECK_EN.
module load_store_unit #(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrite, StResp} state_e;

  localparam logic [2:0] RdLat = 3'(MEM_RD_LAT);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      lane_q, lane_d;
  logic            we_q, we_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic            funct3_ok, misaligned, region_err, req_err;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data, merge_data;

  // Unsigned sizes exist only for loads.
  always_comb begin
    funct3_ok = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = ~req_we;
      default:                funct3_ok = 1'b0;
    endcase
  end

  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_REGION_CHECK_EN
  assign region_err = (req_addr[31:16] == 16'h0000) || (req_addr[31:16] >= 16'hFF10) ||
                      (req_we && (req_addr[31:16] >= 16'h0001) && (req_addr[31:16] <= 16'h000F));
`else
  assign region_err = 1'b0;
`endif

  assign req_err = ~funct3_ok | misaligned | region_err;

  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'h000000, byte_sel};
      3'b101:  load_data = {16'h0000, half_sel};
      default: load_data = mem_rdata;
    endcase
    merge_data = mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      merge_data[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_data[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          funct3_d     = req_funct3;
          lane_d       = req_addr[1:0];
          we_d         = req_we;
          wdata_d      = req_wdata[15:0];
          resp_rdata_d = '0;
          resp_err_d   = req_err;
          if (req_err) begin
            state_d = StResp;
          end else begin
            mem_addr_d = {req_addr[XLEN-1:2], 2'b00};
            if (req_we && (req_funct3[1:0] == 2'b10)) begin
              mem_wdata_d = req_wdata;
              state_d     = StWrite;
            end else begin
              cnt_d   = RdLat;
              state_d = StRdWait;
            end
          end
        end
      end
      StRdWait: begin
        if (cnt_q == 3'd0) begin
          if (we_q) begin
            mem_wdata_d = merge_data;
            state_d     = StWrite;
          end else begin
            resp_rdata_d = load_data;
            state_d      = StResp;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      funct3_q     <= '0;
      lane_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign mem_we     = (state_q == StWrite);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort sequence and random
// requests checked against a byte-level reference model and a latency-modelled memory.
module tb_load_store_unit;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  load_store_unit #(.MEM_RD_LAT(LAT), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Memory: 16 words aliased by addr[5:2]; read data only valid LAT cycles after the
  // address has been presented by a busy unit.
  logic [31:0] mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  logic        prev_busy = 1'b0;
  logic [31:0] prev_addr = '0;
  int          age_prev = 0, age_cur;

  always_comb age_cur = (prev_busy && (mem_addr == prev_addr)) ? age_prev + 1 : 0;
  assign mem_rdata = (age_cur >= LAT) ? mem[mem_addr[5:2]] : 32'h5A5A_A5A5;

  always @(posedge clk) begin
    prev_busy <= ~req_ready;
    prev_addr <= mem_addr;
    age_prev  <= age_cur;
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
  end

  int          wr_total = 0, resp_total = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  always @(negedge clk) begin
    if (mem_we) begin
      wr_total   <= wr_total + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (resp_valid) resp_total <= resp_total + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  function automatic void ref_model(input logic we, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] word, output logic err,
                                    output logic [31:0] rdata, output logic wr,
                                    output logic [31:0] wval, output int lat);
    int size, off;
    logic legal;
    logic [31:0] v;
    off  = int'(addr[1:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal || (off % size != 0);
`ifdef LSU_REGION_CHECK_EN
    if (addr[31:16] == 16'h0000 || addr[31:16] >= 16'hFF10) err = 1'b1;
    if (we && addr[31:16] >= 16'h0001 && addr[31:16] <= 16'h000F) err = 1'b1;
`endif
    rdata = '0; wr = 1'b0; wval = '0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = word >> (8 * off);
      if (size < 4) begin
        v = v & ((32'h1 << (8 * size)) - 32'h1);
        if (!f3[2] && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      end
      rdata = v;
      lat = LAT + 2;
    end else begin
      wr = 1'b1;
      wval = word;
      for (int i = 0; i < size; i++) wval[8*(off+i) +: 8] = wdata[8*i +: 8];
      lat = (size == 4) ? 2 : LAT + 3;
    end
  endfunction

  logic [31:0] exp_maddr = '0;

  // Issue one request from a negedge and compare everything observable until it retires.
  task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic e_err, input logic [31:0] e_rdata, input logic e_wr,
                         input logic [31:0] e_wval, input int e_lat);
    int w0, lat, wait_cnt;
    logic [31:0] rd, ma;
    logic er;
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
    chk({name, "/ready"}, 32'(req_ready), 32'd1);
    w0 = wr_total;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 30) begin @(negedge clk); lat++; end
    rd = resp_rdata; er = resp_err; ma = mem_addr;
    if (!e_err) exp_maddr = {addr[31:2], 2'b00};
    chk({name, "/lat"}, 32'(lat), 32'(e_lat));
    chk({name, "/err"}, 32'(er), 32'(e_err));
    chk({name, "/rdata"}, rd, e_rdata);
    chk({name, "/mem_addr"}, ma, exp_maddr);
    @(negedge clk);
    chk({name, "/pulse"}, 32'(resp_valid), 32'd0);
    chk({name, "/nwr"}, 32'(wr_total - w0), e_wr ? 32'd1 : 32'd0);
    if (e_wr) begin
      chk({name, "/waddr"}, last_waddr, exp_maddr);
      chk({name, "/wdata"}, last_wdata, e_wval);
    end
  endtask

  typedef struct {
    string name; logic we; logic [2:0] f3; logic [31:0] addr, wdata, init;
    logic e_err; logic [31:0] e_rdata; logic e_wr; logic [31:0] e_wval; int e_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ini,
                              input logic er, input logic [31:0] rd, input logic wr,
                              input logic [31:0] wv, input int lat);
    vec_t v;
    v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.init = ini;
    v.e_err = er; v.e_rdata = rd; v.e_wr = wr; v.e_wval = wv; v.e_lat = lat;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e_err, e_wr;
    logic [31:0] e_rd, e_wv, a, wd;
    logic [15:0] hi;
    logic [2:0]  f3;
    logic        we;
    int          e_lat, w0, r0;

    #3;
    chk("rst/ready", 32'(req_ready), 32'd1);
    chk("rst/outs", {27'd0, resp_valid, resp_err, mem_we, 2'b00}, 32'd0);
    chk("rst/mem_addr", mem_addr, 32'd0);
    chk("rst/mem_wdata", mem_wdata, 32'd0);
    chk("rst/rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) poke(4'(i), $urandom);

    vecs.push_back(mk("lw", 0, 3'b010, 32'h0010_0008, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, LAT+2));
    vecs.push_back(mk("lb", 0, 3'b000, 32'h0010_0003, 0, 32'h80AA_BBCC, 0, 32'hFFFF_FF80, 0, 0, LAT+2));
    vecs.push_back(mk("lbu", 0, 3'b100, 32'h0010_0003, 0, 32'h80AA_BBCC, 0, 32'h0000_0080, 0, 0, LAT+2));
    vecs.push_back(mk("lhu", 0, 3'b101, 32'h0010_0002, 0, 32'h80AA_BBCC, 0, 32'h0000_80AA, 0, 0, LAT+2));
    vecs.push_back(mk("lh", 0, 3'b001, 32'h0010_0002, 0, 32'h80AA_BBCC, 0, 32'hFFFF_80AA, 0, 0, LAT+2));
    vecs.push_back(mk("sb", 1, 3'b000, 32'h0010_0001, 32'h0000_0055, 32'h1122_3344, 0, 0, 1, 32'h1122_5544, LAT+3));
    vecs.push_back(mk("sh", 1, 3'b001, 32'h0010_0002, 32'h0000_ABCD, 32'h1122_3344, 0, 0, 1, 32'hABCD_3344, LAT+3));
    vecs.push_back(mk("sw", 1, 3'b010, 32'h0010_0004, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 32'hCAFE_F00D, 2));
    vecs.push_back(mk("lw_mis", 0, 3'b010, 32'h0010_0006, 0, 32'h0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("lh_mis", 0, 3'b001, 32'h0010_0001, 0, 32'h0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("f3_011", 0, 3'b011, 32'h0010_0000, 0, 32'h0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("sbu_ill", 1, 3'b100, 32'h0010_0000, 0, 32'h0, 1, 0, 0, 0, 1));
`ifdef LSU_REGION_CHECK_EN
    vecs.push_back(mk("sw_rom", 1, 3'b010, 32'h0001_0000, 32'h1234_5678, 32'h0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("lw_hi", 0, 3'b010, 32'hFF10_0000, 0, 32'h0BAD_F00D, 1, 0, 0, 0, 1));
`else
    vecs.push_back(mk("sw_rom", 1, 3'b010, 32'h0001_0000, 32'h1234_5678, 32'h0, 0, 0, 1, 32'h1234_5678, 2));
    vecs.push_back(mk("lw_hi", 0, 3'b010, 32'hFF10_0000, 0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 0, 0, LAT+2));
`endif

    foreach (vecs[i]) begin
      poke(vecs[i].addr[5:2], vecs[i].init);
      run_req(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              vecs[i].e_err, vecs[i].e_rdata, vecs[i].e_wr, vecs[i].e_wval, vecs[i].e_lat);
    end

    // Reset while an SB sits in its read phase: nothing may reach memory or the core.
    poke(4'd1, 32'h1122_3344);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h0010_0005; req_wdata = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    w0 = wr_total; r0 = resp_total;
    rst = 1'b0;
    #1;
    chk("abort/ready", 32'(req_ready), 32'd1);
    chk("abort/outs", {29'd0, resp_valid, resp_err, mem_we}, 32'd0);
    chk("abort/mem_addr", mem_addr, 32'd0);
    chk("abort/mem_wdata", mem_wdata, 32'd0);
    chk("abort/rdata", resp_rdata, 32'd0);
    exp_maddr = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort/no_write", 32'(wr_total - w0), 32'd0);
    chk("abort/no_resp", 32'(resp_total - r0), 32'd0);
    chk("abort/mem_kept", mem[1], 32'h1122_3344);
    run_req("after_rst", 1'b1, 3'b000, 32'h0010_0005, 32'h0000_0077,
            1'b0, 32'h0, 1'b1, 32'h1122_7744, LAT+3);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: hi = 16'h0000;
        1: hi = 16'h0005;
        2: hi = 16'hFF10;
        3: hi = 16'h8000;
        4: hi = 16'($urandom);
        default: hi = 16'h0010;
      endcase
      a  = {hi, 10'($urandom), 4'($urandom), 2'($urandom)};
      wd = $urandom;
      we = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom);
      end
      if ($urandom_range(0, 1) == 1) poke(a[5:2], $urandom);
      ref_model(we, f3, a, wd, mem[a[5:2]], e_err, e_rd, e_wr, e_wv, e_lat);
      run_req($sformatf("rnd%0d", i), we, f3, a, wd, e_err, e_rd, e_wr, e_wv, e_lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
